fc_func: RTL and testbench
==========================

# fc_func

Functional (activation) unit of a fully-connected layer, placed directly downstream of the layer's `fc_ctrl` and upstream of the next layer's input buffer. When the controller pulses `o_func_start`, the unit reads the CIM output buffer one word at a time and applies ReLU, requantization shift and unsigned saturation to each element. It writes the resulting DATA_SIZE-bit activations into the next layer's ibuf, then hands off to the next layer's controller with a start pulse.

## Interface
- DATA_SIZE, 8, activation width written to next ibuf
- XBAR_SIZE, 256, crossbar rows; sets accumulator growth
- OBUF_DATA_SIZE, 2*DATA_SIZE+$clog2(XBAR_SIZE) (=24), signed width of one obuf element
- NUM_CHANNELS, 2, elements per obuf word / per ibuf write
- NUM_ELEMS, 32, output elements to process (XBAR_SIZE/DATA_SIZE)
- NUM_WORDS, (NUM_ELEMS+NUM_CHANNELS-1)/NUM_CHANNELS (=16), obuf words read
- SHIFT, 8, requantization right-shift amount (0..OBUF_DATA_SIZE-1)

- clk  in  1  clock, rising edge
- rst  in  1  reset: asynchronous and active-low
- i_start  in  1  start pulse from this layer's ctrl (`o_func_start`)
- o_ready  out  1  unit idle; drives ctrl `i_func_ready`
- o_obuf_re  out  1  obuf read enable
- o_obuf_addr  out  $clog2(NUM_WORDS)  obuf word address
- i_obuf_data  in  NUM_CHANNELS*OBUF_DATA_SIZE  obuf word; element k at bits [k*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]; valid the cycle after o_obuf_re
- i_next_ready  in  1  next layer ctrl idle (its `o_ready`)
- o_ibuf_we  out  1  next ibuf write enable
- o_ibuf_addr  out  $clog2(NUM_WORDS)  next ibuf word address
- o_ibuf_data  out  NUM_CHANNELS*DATA_SIZE  activations; lane k at bits [k*DATA_SIZE +: DATA_SIZE]
- o_next_start  out  1  start pulse to next layer ctrl (`i_start`)

## Operation
- States: IDLE, WAIT, READ, DRAIN, DONE.
- IDLE: o_ready=1, all other outputs 0.
  - On i_start=1, go to READ if i_next_ready=1, else go to WAIT.
- WAIT: o_ready=0. Go to READ once i_next_ready=1. This prevents overwriting an ibuf still being consumed.
- READ: o_obuf_re=1 and o_obuf_addr=rd_cnt, where rd_cnt runs 0..NUM_WORDS-1, one step per cycle.
  - After addr NUM_WORDS-1, go to DRAIN.
- Two-stage pipeline:
  - Stage 1: captures a valid flag and the word address for returning data.
  - Stage 2: registers the computed o_ibuf_data with o_ibuf_we=1 and o_ibuf_addr equal to the source obuf address.
- DRAIN: lasts 2 cycles, until the last write has been issued. Then go to DONE.
- DONE: o_next_start=1 for exactly one cycle, then go to IDLE.
- Per-element arithmetic, element x signed OBUF_DATA_SIZE:
  - r = (x<0) ? 0 : x.
  - s = r >> SHIFT, logical.
  - y = (s > 2^DATA_SIZE-1) ? 2^DATA_SIZE-1 : s[DATA_SIZE-1:0].
- Partial last word: when NUM_ELEMS is not a multiple of NUM_CHANNELS, lanes with index ≥ NUM_ELEMS in the last word are written as 0.
- i_start while o_ready=0 is ignored; no queuing.
- i_next_ready is sampled only in IDLE and WAIT. Its deassertion during READ or DRAIN has no effect.
- Reset (rst=0, any time, including mid-operation):
  - State goes to IDLE immediately.
  - Counters and pipeline valids are cleared; pending writes are dropped.
  - o_ready=1; o_obuf_re, o_ibuf_we, o_next_start, addresses and data are all 0.

## Timing
- Cycle 0: i_start accepted in IDLE with i_next_ready=1. o_ready falls at cycle 1.
- Cycles 1..NUM_WORDS: o_obuf_re=1 with addresses 0..NUM_WORDS-1.
- Cycles 3..NUM_WORDS+2: o_ibuf_we=1 with addresses 0..NUM_WORDS-1. Read-to-write latency is 2 cycles.
- Cycle NUM_WORDS+3: o_next_start=1. This is 19 cycles for the defaults.
- Cycle NUM_WORDS+4: o_ready=1 again.
- Each cycle spent in WAIT delays every later event by one cycle.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Reset mid-READ: assert rst=0 at cycle 5 of a run. Required: o_ready=1 and o_obuf_re=0 asynchronously, with no o_ibuf_we afterwards. A new i_start then runs cleanly.
- Nominal run (defaults), with obuf word w = {elem1=w*512, elem0=w*256} and i_next_ready=1. Required:
  - 16 writes at cycles 3..18, addr w, lane0=w and lane1=2w.
  - o_next_start at cycle 19 only.
- Arithmetic corners on the element values below. Required outputs after ReLU, SHIFT=8 and saturation:
  - x=-1 → 0
  - x=0x0000FF → 0
  - x=0x000100 → 1
  - x=0x00FFFF → 255
  - x=0x010000 → 255 (saturates)
  - x=0x7FFFFF → 255
- Backpressure: i_next_ready=0 when i_start arrives and held for 10 cycles. Required: no o_obuf_re during the 10 WAIT cycles, then the nominal sequence shifted by 10 cycles.
- Busy start: pulse i_start again during READ and during DONE. Required: ignored, exactly one o_next_start, and the write count stays 16.
- Odd size (NUM_ELEMS=31, NUM_WORDS=16), with every obuf element = 0x000500. Required: words 0..14 written with both lanes = 5; word 15 written with lane0=5 and lane1=0.

Source files
------------

// File: rtl/fc_func.sv
// Activation stage of a fully-connected layer: streams the CIM output buffer through
// ReLU, requantization shift and unsigned saturation into the next layer's input buffer.
module fc_func #(
  parameter int DATA_SIZE      = 8,
  parameter int XBAR_SIZE      = 256,
  parameter int OBUF_DATA_SIZE = 2*DATA_SIZE + $clog2(XBAR_SIZE),
  parameter int NUM_CHANNELS   = 2,
  parameter int NUM_ELEMS      = 32,
  parameter int NUM_WORDS      = (NUM_ELEMS + NUM_CHANNELS - 1) / NUM_CHANNELS,
  parameter int SHIFT          = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  output logic                                   o_ready,
  output logic                                   o_obuf_re,
  output logic [$clog2(NUM_WORDS)-1:0]           o_obuf_addr,
  input  logic [NUM_CHANNELS*OBUF_DATA_SIZE-1:0] i_obuf_data,
  input  logic                                   i_next_ready,
  output logic                                   o_ibuf_we,
  output logic [$clog2(NUM_WORDS)-1:0]           o_ibuf_addr,
  output logic [NUM_CHANNELS*DATA_SIZE-1:0]      o_ibuf_data,
  output logic                                   o_next_start
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam logic [OBUF_DATA_SIZE-1:0] ACT_MAX =
    {{(OBUF_DATA_SIZE-DATA_SIZE){1'b0}}, {DATA_SIZE{1'b1}}};

  typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, DONE} state_t;

  state_t                            r_state;
  logic   [AW-1:0]                   r_rd_cnt;
  logic                              r_drain;
  logic                              r_vld_p1;
  logic   [AW-1:0]                   r_addr_p1;
  logic                              r_vld_p2;
  logic   [AW-1:0]                   r_addr_p2;
  logic   [NUM_CHANNELS*DATA_SIZE-1:0] r_data_p2;
  logic   [NUM_CHANNELS*DATA_SIZE-1:0] w_act;

  function automatic logic [DATA_SIZE-1:0] relu_shift_sat(
    input logic signed [OBUF_DATA_SIZE-1:0] x
  );
    logic [OBUF_DATA_SIZE-1:0] s;
    if (x[OBUF_DATA_SIZE-1]) return '0;
    s = $unsigned(x) >> SHIFT;
    if (s > ACT_MAX) return {DATA_SIZE{1'b1}};
    return s[DATA_SIZE-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rd_cnt <= '0;
      r_drain  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rd_cnt <= '0;
          if (i_start) r_state <= i_next_ready ? READ : WAIT;
        end
        WAIT: begin
          if (i_next_ready) r_state <= READ;
        end
        READ: begin
          if (r_rd_cnt == AW'(NUM_WORDS-1)) begin
            r_rd_cnt <= '0;
            r_drain  <= 1'b0;
            r_state  <= DRAIN;
          end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Two drain cycles cover the read-to-write latency of the pipeline.
          r_drain <= 1'b1;
          if (r_drain) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage 1: obuf data returns one cycle after the read, tag it with its address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
    end else begin
      r_vld_p1  <= (r_state == READ);
      r_addr_p1 <= (r_state == READ) ? r_rd_cnt : '0;
    end
  end

  // Lanes past NUM_ELEMS in a partial last word are forced to zero.
  always_comb begin
    w_act = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (int'(r_addr_p1) * NUM_CHANNELS + k < NUM_ELEMS)
        w_act[k*DATA_SIZE +: DATA_SIZE] =
          relu_shift_sat(i_obuf_data[k*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]);
    end
  end

  // Stage 2: registered write to the next layer's ibuf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p2  <= 1'b0;
      r_addr_p2 <= '0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_addr_p2 <= r_vld_p1 ? r_addr_p1 : '0;
      r_data_p2 <= r_vld_p1 ? w_act : '0;
    end
  end

  assign o_ready      = (r_state == IDLE);
  assign o_obuf_re    = (r_state == READ);
  assign o_obuf_addr  = r_rd_cnt;
  assign o_ibuf_we    = r_vld_p2;
  assign o_ibuf_addr  = r_addr_p2;
  assign o_ibuf_data  = r_data_p2;
  assign o_next_start = (r_state == DONE);

endmodule

// File: tb/tb_fc_func.sv
// Scoreboard bench for fc_func: a full-size instance and an odd-size (31 element) instance
// share one obuf image; expected ibuf writes are queued at start and popped by a monitor.
`timescale 1ns/1ps
module tb_fc_func;
  localparam int DS = 8;
  localparam int OS = 24;
  localparam int NC = 2;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int SH = 8;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic nrdy [2];
  logic rdy [2];
  logic re [2];
  logic [AW-1:0] raddr [2];
  logic [NC*OS-1:0] rdata [2];
  logic we [2];
  logic [AW-1:0] waddr [2];
  logic [NC*DS-1:0] wdata [2];
  logic nstart [2];

  logic signed [OS-1:0] mem [NW][NC];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {int c; int addr; logic [NC*DS-1:0] data;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int exp_ns [2];
  int nwr [2];
  int nns [2];

  fc_func #(.NUM_ELEMS(32)) u_dut0 (
    .clk(clk), .rst(rst), .i_start(start[0]), .o_ready(rdy[0]),
    .o_obuf_re(re[0]), .o_obuf_addr(raddr[0]), .i_obuf_data(rdata[0]),
    .i_next_ready(nrdy[0]), .o_ibuf_we(we[0]), .o_ibuf_addr(waddr[0]),
    .o_ibuf_data(wdata[0]), .o_next_start(nstart[0])
  );

  fc_func #(.NUM_ELEMS(31)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start[1]), .o_ready(rdy[1]),
    .o_obuf_re(re[1]), .o_obuf_addr(raddr[1]), .i_obuf_data(rdata[1]),
    .i_next_ready(nrdy[1]), .o_ibuf_we(we[1]), .o_ibuf_addr(waddr[1]),
    .o_ibuf_data(wdata[1]), .o_next_start(nstart[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Obuf model: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    rdata[0] <= {mem[raddr[0]][1], mem[raddr[0]][0]};
    rdata[1] <= {mem[raddr[1]][1], mem[raddr[1]][0]};
  end

  function automatic logic [DS-1:0] act(input logic signed [OS-1:0] x);
    int v;
    v = int'(x);
    if (v < 0) return '0;
    v = v / (1 << SH);
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [NC*DS-1:0] exp_word(input int sel, input int w);
    logic [NC*DS-1:0] r;
    int ne;
    r = '0;
    ne = (sel == 1) ? 31 : 32;
    for (int k = 0; k < NC; k++)
      if (w * NC + k < ne) r[k*DS +: DS] = act(mem[w][k]);
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int s = 0; s < 2; s++) begin
          if (we[s]) begin
            nwr[s]++;
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_write: addr %0d data %0h, no write expected (cycle %0d)",
                       s, waddr[s], wdata[s], cyc);
            end else begin
              if (s == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk($sformatf("dut%0d write_cycle a%0d", s, e.addr), cyc, e.c);
              chk($sformatf("dut%0d write_addr", s), int'(waddr[s]), e.addr);
              chk($sformatf("dut%0d write_data a%0d", s, e.addr), int'(wdata[s]), int'(e.data));
            end
          end
          if (nstart[s]) begin
            nns[s]++;
            chk($sformatf("dut%0d next_start_cycle", s), cyc, exp_ns[s]);
          end
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < NW; w++)
      for (int k = 0; k < NC; k++)
        case ($urandom_range(0, 2))
          0:       mem[w][k] = OS'($urandom);
          1:       mem[w][k] = OS'($urandom_range(0, 'h1FFFF));
          default: mem[w][k] = -OS'($urandom_range(1, 1000));
        endcase
  endtask

  task automatic fill_nominal();
    for (int w = 0; w < NW; w++) begin
      mem[w][0] = OS'(w * 256);
      mem[w][1] = OS'(w * 512);
    end
  endtask

  task automatic push_run(input int sel, input int c0, input int wait_c);
    exp_t e;
    for (int w = 0; w < NW; w++) begin
      e.c = c0 + wait_c + 3 + w;
      e.addr = w;
      e.data = exp_word(sel, w);
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    exp_ns[sel] = c0 + wait_c + NW + 3;
  endtask

  task automatic wait_ready(input int sel);
    int n;
    n = 0;
    while (!rdy[sel] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("dut%0d ready_before_start", sel), int'(rdy[sel]), 1);
  endtask

  task automatic run(input int sel, input int wait_c, input bit busy);
    int c0, nw0, nn0, qs;
    wait_ready(sel);
    @(posedge clk); #1;
    c0 = cyc;
    push_run(sel, c0, wait_c);
    nw0 = nwr[sel];
    nn0 = nns[sel];
    start[sel] = 1'b1;
    nrdy[sel] = (wait_c == 0);
    for (int i = 1; i <= wait_c + NW + 6; i++) begin
      @(posedge clk); #1;
      start[sel] = busy && (i == wait_c + 5 || i == wait_c + NW + 3);
      if (i == wait_c) nrdy[sel] = 1'b1;
      if (i <= wait_c) chk($sformatf("dut%0d wait_no_read", sel), int'(re[sel]), 0);
      if (i == wait_c + 1) begin
        chk($sformatf("dut%0d first_read_en", sel), int'(re[sel]), 1);
        chk($sformatf("dut%0d first_read_addr", sel), int'(raddr[sel]), 0);
        chk($sformatf("dut%0d busy_ready_low", sel), int'(rdy[sel]), 0);
      end
      if (i == wait_c + NW + 4) chk($sformatf("dut%0d ready_after_done", sel), int'(rdy[sel]), 1);
    end
    start[sel] = 1'b0;
    qs = (sel == 0) ? q0.size() : q1.size();
    chk($sformatf("dut%0d write_count", sel), nwr[sel] - nw0, NW);
    chk($sformatf("dut%0d next_start_count", sel), nns[sel] - nn0, 1);
    chk($sformatf("dut%0d pending_writes", sel), qs, 0);
  endtask

  task automatic reset_mid_read();
    int c0, nw0, nn0;
    fill_nominal();
    wait_ready(0);
    @(posedge clk); #1;
    c0 = cyc;
    push_run(0, c0, 0);
    start[0] = 1'b1;
    nrdy[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    #1 rst = 1'b0;
    #1;
    chk("reset_ready", int'(rdy[0]), 1);
    chk("reset_obuf_re", int'(re[0]), 0);
    chk("reset_ibuf_we", int'(we[0]), 0);
    chk("reset_ibuf_data", int'(wdata[0]), 0);
    chk("reset_obuf_addr", int'(raddr[0]), 0);
    q0.delete();
    exp_ns[0] = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    nw0 = nwr[0];
    nn0 = nns[0];
    repeat (25) @(posedge clk);
    #1;
    chk("no_write_after_reset", nwr[0] - nw0, 0);
    chk("no_next_start_after_reset", nns[0] - nn0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    nrdy[0] = 1'b1;  nrdy[1] = 1'b1;
    exp_ns[0] = -1;  exp_ns[1] = -1;
    nwr[0] = 0; nwr[1] = 0; nns[0] = 0; nns[1] = 0;
    for (int w = 0; w < NW; w++) begin
      mem[w][0] = '0;
      mem[w][1] = '0;
    end
    fork
      monitor();
    join_none
    #1 rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("dut%0d init_ready", s), int'(rdy[s]), 1);
      chk($sformatf("dut%0d init_obuf_re", s), int'(re[s]), 0);
      chk($sformatf("dut%0d init_ibuf_we", s), int'(we[s]), 0);
      chk($sformatf("dut%0d init_next_start", s), int'(nstart[s]), 0);
      chk($sformatf("dut%0d init_ibuf_addr", s), int'(waddr[s]), 0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    fill_nominal();
    run(0, 0, 1'b0);

    fill_random();
    mem[0][0] = -OS'(1);      mem[0][1] = OS'('h0000FF);
    mem[1][0] = OS'('h000100); mem[1][1] = OS'('h00FFFF);
    mem[2][0] = OS'('h010000); mem[2][1] = OS'('h7FFFFF);
    run(0, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run(0, 0, 1'b0);
    end

    fill_nominal();
    run(0, 10, 1'b0);

    fill_random();
    run(0, 0, 1'b1);

    reset_mid_read();
    fill_nominal();
    run(0, 0, 1'b0);

    for (int w = 0; w < NW; w++) begin
      mem[w][0] = OS'('h000500);
      mem[w][1] = OS'('h000500);
    end
    run(1, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
